// File: rtl/time_set_stepper.sv
// Cuckoo clock time-setting stepper: turns set-button presses and long-press holds into
// BCD hour/minute increments with accelerating auto-repeat, and keeps time from minTick in run mode.
module time_set_stepper #(
  parameter int unsigned REPEAT_SLOW = 5,
  parameter int unsigned REPEAT_FAST = 2,
  parameter int unsigned ACCEL_COUNT = 8
) (
  input  logic       clk10hz,
  input  logic       rstn,
  input  logic       pb,
  input  logic       isKP,
  input  logic       setEn,
  input  logic       sel,
  input  logic       minTick,
  output logic [7:0] hourBcd,
  output logic [7:0] minBcd,
  output logic       stepPulse
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_RPT_SLOW = 2'd2,
    ST_RPT_FAST = 2'd3
  } state_t;

  localparam logic [7:0] SLOW_LAST = 8'(REPEAT_SLOW - 1);
  localparam logic [7:0] FAST_LAST = 8'(REPEAT_FAST - 1);
  localparam logic [7:0] ACCEL_LIM = 8'(ACCEL_COUNT);

  state_t     state_q, state_d;
  logic [7:0] tick_q, tick_d;
  logic [7:0] rep_q, rep_d;
  logic [7:0] hour_q, hour_d;
  logic [7:0] min_q, min_d;
  logic       step_q;
  logic       pb_q;
  logic       step_s;
  logic       press_s;
  logic       exit_s;
  logic [7:0] rep_next_s;

  function automatic logic [7:0] inc_min(input logic [7:0] v);
    if (v == 8'h59) begin
      return 8'h00;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    if (v == 8'h23) begin
      return 8'h00;
    end else if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end else begin
      return {v[7:4], v[3:0] + 4'd1};
    end
  endfunction

  assign press_s    = pb_q & ~pb;
  assign exit_s     = pb | ~setEn;
  assign rep_next_s = (rep_q == ACCEL_LIM) ? rep_q : rep_q + 8'd1;

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    rep_d   = rep_q;
    step_s  = 1'b0;
    hour_d  = hour_q;
    min_d   = min_q;
    case (state_q)
      ST_IDLE: begin
        // isKP alone never starts a repeat; only a fresh press edge leaves IDLE
        if (press_s && setEn) begin
          step_s  = 1'b1;
          state_d = ST_PRESSED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESSED: begin
        if (exit_s) begin
          state_d = ST_IDLE;
        end else if (isKP) begin
          state_d = ST_RPT_SLOW;
          tick_d  = 8'd0;
          rep_d   = 8'd0;
        end else begin
          state_d = ST_PRESSED;
        end
      end
      ST_RPT_SLOW: begin
        if (exit_s || !isKP) begin
          state_d = ST_IDLE;
        end else if (tick_q == SLOW_LAST) begin
          step_s = 1'b1;
          tick_d = 8'd0;
          rep_d  = rep_next_s;
          if (rep_next_s == ACCEL_LIM) begin
            state_d = ST_RPT_FAST;
          end else begin
            state_d = ST_RPT_SLOW;
          end
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      ST_RPT_FAST: begin
        if (exit_s || !isKP) begin
          state_d = ST_IDLE;
        end else if (tick_q == FAST_LAST) begin
          step_s = 1'b1;
          tick_d = 8'd0;
        end else begin
          tick_d = tick_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tick_d  = 8'd0;
        rep_d   = 8'd0;
      end
    endcase

    // a setting step always wins over a coincident minute tick
    if (step_s) begin
      if (sel) begin
        hour_d = inc_hour(hour_q);
      end else begin
        min_d = inc_min(min_q);
      end
    end else if (!setEn && minTick) begin
      min_d = inc_min(min_q);
      if (min_q == 8'h59) begin
        hour_d = inc_hour(hour_q);
      end else begin
        hour_d = hour_q;
      end
    end else begin
      hour_d = hour_q;
      min_d  = min_q;
    end
  end

  always_ff @(posedge clk10hz) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      tick_q  <= 8'd0;
      rep_q   <= 8'd0;
      hour_q  <= 8'h00;
      min_q   <= 8'h00;
      step_q  <= 1'b0;
      pb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      rep_q   <= rep_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      step_q  <= step_s;
      pb_q    <= pb;
    end
  end

  assign hourBcd   = hour_q;
  assign minBcd    = min_q;
  assign stepPulse = step_q;

endmodule

// File: tb/tb_time_set_stepper.sv
// Directed self-checking bench for time_set_stepper; inputs change and outputs are
// sampled 1 time unit after each rising clock edge.
module tb_time_set_stepper;

  logic       clk10hz;
  logic       rstn;
  logic       pb;
  logic       isKP;
  logic       setEn;
  logic       sel;
  logic       minTick;
  logic [7:0] hourBcd;
  logic [7:0] minBcd;
  logic       stepPulse;

  int tests;
  int fails;

  time_set_stepper #(
    .REPEAT_SLOW(5),
    .REPEAT_FAST(2),
    .ACCEL_COUNT(8)
  ) dut (
    .clk10hz  (clk10hz),
    .rstn     (rstn),
    .pb       (pb),
    .isKP     (isKP),
    .setEn    (setEn),
    .sel      (sel),
    .minTick  (minTick),
    .hourBcd  (hourBcd),
    .minBcd   (minBcd),
    .stepPulse(stepPulse)
  );

  initial clk10hz = 1'b0;
  always #5 clk10hz = ~clk10hz;

  task automatic cyc();
    @(posedge clk10hz);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; pb = 1'b1; isKP = 1'b0; setEn = 1'b0; sel = 1'b0; minTick = 1'b0;
    cyc(); cyc();
    rstn = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rstn = 1'b0; pb = 1'b1; isKP = 1'b0; setEn = 1'b0; sel = 1'b0; minTick = 1'b0;
    cyc(); cyc();
    tests++;
    if ({hourBcd, minBcd, stepPulse} !== 17'h0) begin
      fails++;
      $display("FAIL reset_state: got %h:%h pulse=%b, want 00:00 pulse=0", hourBcd, minBcd, stepPulse);
    end
    rstn = 1'b1;
    cyc();
  endtask

  task automatic test_short_press();
    int pulses;
    pulses = 0;
    do_reset();
    setEn = 1'b1; sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pb = 1'b0;
      cyc();
      tests++;
      if (stepPulse !== 1'b1) begin
        fails++;
        $display("FAIL short_press_pulse[%0d]: got %b, want 1", i, stepPulse);
      end
      if (stepPulse === 1'b1) pulses++;
      pb = 1'b1;
      cyc();
      tests++;
      if (stepPulse !== 1'b0) begin
        fails++;
        $display("FAIL short_press_pulse_width[%0d]: got %b, want 0", i, stepPulse);
      end
      cyc();
    end
    tests++;
    if (minBcd !== 8'h03 || hourBcd !== 8'h00 || pulses != 3) begin
      fails++;
      $display("FAIL short_press_result: got %h:%h pulses=%0d, want 00:03 pulses=3", hourBcd, minBcd, pulses);
    end
  endtask

  task automatic test_field_wrap();
    do_reset();
    minTick = 1'b1;
    repeat (58) cyc();
    minTick = 1'b0;
    tests++;
    if (minBcd !== 8'h58 || hourBcd !== 8'h00) begin
      fails++;
      $display("FAIL preload_58: got %h:%h, want 00:58", hourBcd, minBcd);
    end
    setEn = 1'b1; sel = 1'b0;
    pb = 1'b0; cyc(); pb = 1'b1; cyc();
    tests++;
    if (minBcd !== 8'h59) begin
      fails++;
      $display("FAIL min_to_59: got %h, want 59", minBcd);
    end
    pb = 1'b0; cyc(); pb = 1'b1; cyc();
    tests++;
    if (minBcd !== 8'h00 || hourBcd !== 8'h00) begin
      fails++;
      $display("FAIL min_wrap_no_carry: got %h:%h, want 00:00", hourBcd, minBcd);
    end
    sel = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      pb = 1'b0; cyc(); pb = 1'b1; cyc();
      if (i == 10) begin
        tests++;
        if (hourBcd !== 8'h10) begin
          fails++;
          $display("FAIL hour_bcd_carry: got %h, want 10", hourBcd);
        end
      end
      if (i == 23) begin
        tests++;
        if (hourBcd !== 8'h23) begin
          fails++;
          $display("FAIL hour_23: got %h, want 23", hourBcd);
        end
      end
    end
    tests++;
    if (hourBcd !== 8'h00 || minBcd !== 8'h00) begin
      fails++;
      $display("FAIL hour_wrap_24: got %h:%h, want 00:00", hourBcd, minBcd);
    end
  endtask

  task automatic test_repeat_hold();
    bit exp;
    int k;
    do_reset();
    setEn = 1'b1; sel = 1'b0;
    pb = 1'b0;
    // cycle k samples the state after the k-th edge with pb low
    for (k = 1; k <= 80; k++) begin
      cyc();
      exp = (k == 1) ||
            (k >= 16 && k <= 51 && ((k - 16) % 5) == 0) ||
            (k >= 53 && k <= 69 && ((k - 53) % 2) == 0);
      tests++;
      if (stepPulse !== exp) begin
        fails++;
        $display("FAIL repeat_pulse@%0d: got %b, want %b", k, stepPulse, exp);
      end
      if (k == 10) isKP = 1'b1;
      if (k == 70) begin
        pb = 1'b1;
        isKP = 1'b0;
      end
    end
    tests++;
    if (minBcd !== 8'h18 || hourBcd !== 8'h00) begin
      fails++;
      $display("FAIL repeat_total: got %h:%h, want 00:18", hourBcd, minBcd);
    end
  endtask

  task automatic test_run_mode();
    do_reset();
    minTick = 1'b1;
    repeat (60) cyc();
    tests++;
    if (hourBcd !== 8'h01 || minBcd !== 8'h00) begin
      fails++;
      $display("FAIL run_carry_hour: got %h:%h, want 01:00", hourBcd, minBcd);
    end
    repeat (1379) cyc();
    tests++;
    if (hourBcd !== 8'h23 || minBcd !== 8'h59) begin
      fails++;
      $display("FAIL run_2359: got %h:%h, want 23:59", hourBcd, minBcd);
    end
    cyc();
    tests++;
    if (hourBcd !== 8'h00 || minBcd !== 8'h00 || stepPulse !== 1'b0) begin
      fails++;
      $display("FAIL run_midnight: got %h:%h pulse=%b, want 00:00 pulse=0", hourBcd, minBcd, stepPulse);
    end
    setEn = 1'b1; sel = 1'b1; pb = 1'b0;
    cyc();
    tests++;
    if (hourBcd !== 8'h01 || minBcd !== 8'h00 || stepPulse !== 1'b1) begin
      fails++;
      $display("FAIL tick_with_step: got %h:%h pulse=%b, want 01:00 pulse=1", hourBcd, minBcd, stepPulse);
    end
    pb = 1'b1;
    repeat (3) cyc();
    minTick = 1'b0;
    tests++;
    if (hourBcd !== 8'h01 || minBcd !== 8'h00) begin
      fails++;
      $display("FAIL tick_ignored_setting: got %h:%h, want 01:00", hourBcd, minBcd);
    end
  endtask

  task automatic test_reset_hold();
    int pulses;
    do_reset();
    setEn = 1'b1; sel = 1'b0;
    rstn = 1'b0; pb = 1'b0;
    cyc(); cyc();
    rstn = 1'b1;
    pulses = 0;
    repeat (5) begin
      cyc();
      if (stepPulse === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0 || minBcd !== 8'h00) begin
      fails++;
      $display("FAIL held_through_reset: got pulses=%0d min=%h, want 0 and 00", pulses, minBcd);
    end
    pb = 1'b1; cyc();
    pb = 1'b0; cyc();
    tests++;
    if (minBcd !== 8'h01 || stepPulse !== 1'b1) begin
      fails++;
      $display("FAIL repress_after_reset: got min=%h pulse=%b, want 01 and 1", minBcd, stepPulse);
    end
    isKP = 1'b1;
    repeat (50) cyc();
    rstn = 1'b0;
    cyc();
    tests++;
    if (hourBcd !== 8'h00 || minBcd !== 8'h00 || stepPulse !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_fast: got %h:%h pulse=%b, want 00:00 pulse=0", hourBcd, minBcd, stepPulse);
    end
    rstn = 1'b1;
    pulses = 0;
    repeat (20) begin
      cyc();
      if (stepPulse === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0 || minBcd !== 8'h00 || hourBcd !== 8'h00) begin
      fails++;
      $display("FAIL no_steps_after_reset: got pulses=%0d %h:%h, want 0 and 00:00", pulses, hourBcd, minBcd);
    end
    pb = 1'b1; isKP = 1'b0;
    cyc();
  endtask

  task automatic test_no_step();
    int pulses;
    do_reset();
    setEn = 1'b1; sel = 1'b0; pb = 1'b1; isKP = 1'b1;
    pulses = 0;
    repeat (12) begin
      cyc();
      if (stepPulse === 1'b1) pulses++;
    end
    tests++;
    if (pulses != 0 || minBcd !== 8'h00) begin
      fails++;
      $display("FAIL iskp_without_press: got pulses=%0d min=%h, want 0 and 00", pulses, minBcd);
    end
    isKP = 1'b0; setEn = 1'b0;
    pulses = 0;
    pb = 1'b0;
    cyc();
    if (stepPulse === 1'b1) pulses++;
    pb = 1'b1;
    cyc();
    if (stepPulse === 1'b1) pulses++;
    tests++;
    if (pulses != 0 || minBcd !== 8'h00 || hourBcd !== 8'h00) begin
      fails++;
      $display("FAIL press_in_run_mode: got pulses=%0d %h:%h, want 0 and 00:00", pulses, hourBcd, minBcd);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    setEn = 1'b1; sel = 1'b0; pb = 1'b0;
    cyc();
    isKP = 1'b1;
    repeat (6) cyc();
    // first repeat step landed; redirect to hours and drop isKP to end the hold
    sel = 1'b1;
    repeat (5) cyc();
    isKP = 1'b0;
    repeat (8) cyc();
    tests++;
    if (minBcd !== 8'h02 || hourBcd !== 8'h01) begin
      fails++;
      $display("FAIL sel_redirect_iskp_drop: got %h:%h, want 01:02", hourBcd, minBcd);
    end
    pb = 1'b1;
    cyc();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_short_press();
    test_field_wrap();
    test_repeat_hold();
    test_run_mode();
    test_reset_hold();
    test_no_step();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
